data_mem_responder: RTL and testbench

- Data-memory responder for the core: answers the mem_read/mem_write requests raised by the instruction decode/control path.
- Performs RISC-V byte, half and word loads and stores, with sign or zero extension selected by funct3.
- Models a fixed-latency memory: request sampled, wait counter, one-cycle ready pulse.
- Sits between the ALU address result and the writeback mux (mem_to_reg path).

---
 rtl/data_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory answering core load/store requests.
// Optional misalignment trap: define DATA_MEM_MISALIGN_TRAP_EN.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW+1:0] addr_q;
    logic [2:0]    f3_q;
    logic [31:0]   wdata_q;
    logic          wr_q;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic          misalign;
    logic [31:0]   load_val;
    logic [3:0]    be;
    logic [31:0]   st_data;

    // Upper address bits only select an alias of the array.
    logic          addr_unused;
    assign addr_unused = ^addr[31:AW+2];

    assign idx  = addr_q[AW+1:2];
    assign lane = addr_q[1:0];
    assign word = mem[idx];

    // Detect accesses whose low address bits do not match the access size.
    always_comb begin
        misalign = 1'b0;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        if (f3_q[1:0] == 2'b01 && addr_q[0])
            misalign = 1'b1;
        if (f3_q == 3'b010 && addr_q[1:0] != 2'b00)
            misalign = 1'b1;
`endif
    end

    // Lane selection and sign/zero extension for loads.
    always_comb begin
        byte_sel = word[8*lane +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        load_val = word;
        case (f3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'h0, byte_sel};
            3'b101:  load_val = {16'h0, half_sel};
            default: load_val = word;
        endcase
        if (misalign)
            load_val = 32'h0;
    end

    // Byte enables and lane-replicated store data.
    always_comb begin
        be      = 4'b0000;
        st_data = wdata_q;
        case (f3_q)
            3'b000: begin
                be      = 4'b0001 << lane;
                st_data = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata_q[15:0]}};
            end
            3'b010: begin
                be      = 4'b1111;
                st_data = wdata_q;
            end
            default: begin
                be      = 4'b0000;
                st_data = wdata_q;
            end
        endcase
        if (misalign)
            be = 4'b0000;
    end

    // Request FSM with registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rdata   <= 32'h0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            error   <= 1'b0;
            cnt     <= '0;
            addr_q  <= '0;
            f3_q    <= 3'b000;
            wdata_q <= 32'h0;
            wr_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    error <= 1'b0;
                    if (mem_read || mem_write) begin
                        addr_q  <= addr[AW+1:0];
                        f3_q    <= funct3;
                        wdata_q <= wdata;
                        wr_q    <= mem_write;
                        cnt     <= CNT_INIT;
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        ready <= 1'b1;
                        error <= misalign;
                        if (!wr_q)
                            rdata <= load_val;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    error <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    error <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Store commits at the close of the response cycle.
    always_ff @(posedge clk) begin
        if (state == RESP && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (LATENCY=1).
// Expectations follow DATA_MEM_MISALIGN_TRAP_EN when defined.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        error;

    int tests_run;
    int tests_failed;

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        bok;

    data_mem_responder #(
        .DEPTH(256),
        .LATENCY(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .funct3(funct3),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .ready(ready),
        .busy(busy),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request; return response data, error, edges to ready,
    // and whether busy/ready framed the transaction correctly.
    task automatic do_access(input logic r, input logic w,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd,
                             output logic [31:0] rdo, output logic erro,
                             output int lato, output logic bko);
        rdo  = 'x;
        erro = 'x;
        lato = -1;
        @(negedge clk);
        mem_read = r; mem_write = w;
        funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        bko = busy && !ready;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (!busy) bko = 1'b0;
            if (ready) begin
                lato = k;
                rdo  = rdata;
                erro = error;
                break;
            end
        end
        @(posedge clk); #1;
        if (busy || ready) bko = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (rdata !== 32'h0 || ready !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs rdata=%h ready=%b busy=%b error=%b exp 0", rdata, ready, busy, error);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word;
        do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, bok);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL sw_latency edges=%0d exp=1", lat);
        end
        tests_run++;
        if (bok !== 1'b1) begin
            tests_failed++;
            $display("FAIL sw_busy_frame got=%b exp=1", bok);
        end
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL sw_rdata_held rdata=%h exp=%h", rd, 32'h0);
        end
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, bok);
        tests_run++;
        if (lat !== 1 || bok !== 1'b1) begin
            tests_failed++;
            $display("FAIL lw_timing edges=%0d frame=%b exp 1/1", lat, bok);
        end
        tests_run++;
        if (rd !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL lw_word rdata=%h exp=%h", rd, 32'hDEADBEEF);
        end
    endtask

    task automatic test_load_ext;
        logic [2:0]  f3v [7];
        logic [31:0] av  [7];
        logic [31:0] ev  [7];
        f3v[0] = 3'b000; av[0] = 32'h13; ev[0] = 32'hFFFFFFDE;
        f3v[1] = 3'b100; av[1] = 32'h13; ev[1] = 32'h000000DE;
        f3v[2] = 3'b001; av[2] = 32'h12; ev[2] = 32'hFFFFDEAD;
        f3v[3] = 3'b101; av[3] = 32'h10; ev[3] = 32'h0000BEEF;
        f3v[4] = 3'b000; av[4] = 32'h10; ev[4] = 32'hFFFFFFEF;
        f3v[5] = 3'b100; av[5] = 32'h11; ev[5] = 32'h000000BE;
        f3v[6] = 3'b011; av[6] = 32'h10; ev[6] = 32'hDEADBEEF;
        for (int i = 0; i < 7; i++) begin
            do_access(1'b1, 1'b0, f3v[i], av[i], 32'h0, rd, er, lat, bok);
            tests_run++;
            if (rd !== ev[i]) begin
                tests_failed++;
                $display("FAIL load_ext[%0d] f3=%b addr=%h rdata=%h exp=%h", i, f3v[i], av[i], rd, ev[i]);
            end
        end
    endtask

    task automatic test_store_lanes;
        do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, rd, er, lat, bok);
        do_access(1'b0, 1'b1, 3'b000, 32'h11, 32'h00000055, rd, er, lat, bok);
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, bok);
        tests_run++;
        if (rd !== 32'h00005500) begin
            tests_failed++;
            $display("FAIL sb_lane rdata=%h exp=%h", rd, 32'h00005500);
        end
        do_access(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000A5A5, rd, er, lat, bok);
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, bok);
        tests_run++;
        if (rd !== 32'hA5A55500) begin
            tests_failed++;
            $display("FAIL sh_lane rdata=%h exp=%h", rd, 32'hA5A55500);
        end
        do_access(1'b0, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, rd, er, lat, bok);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL bad_store_ready edges=%0d exp=1", lat);
        end
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, bok);
        tests_run++;
        if (rd !== 32'hA5A55500) begin
            tests_failed++;
            $display("FAIL bad_store_nowrite rdata=%h exp=%h", rd, 32'hA5A55500);
        end
        do_access(1'b1, 1'b0, 3'b010, 32'h410, 32'h0, rd, er, lat, bok);
        tests_run++;
        if (rd !== 32'hA5A55500) begin
            tests_failed++;
            $display("FAIL addr_wrap rdata=%h exp=%h", rd, 32'hA5A55500);
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        do_access(1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, rd, er, lat, bok);
        do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, bok);
        seen = 1'b0;
        @(negedge clk);
        mem_write = 1'b1; funct3 = 3'b010;
        addr = 32'h20; wdata = 32'h12345678;
        @(posedge clk); #1;
        mem_write = 1'b0;
        rst = 1'b1;
        #1;
        tests_run++;
        if (rdata !== 32'h0 || ready !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs rdata=%h ready=%b busy=%b error=%b exp 0", rdata, ready, busy, error);
        end
        repeat (2) begin
            @(posedge clk); #1;
            if (ready) seen = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ready) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_ready pulsed=%b exp=0", seen);
        end
        do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, bok);
        tests_run++;
        if (rd !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL reset_mid_nowrite rdata=%h exp=%h", rd, 32'hCAFEF00D);
        end
    endtask

    task automatic test_both_high;
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, bok);
        do_access(1'b1, 1'b1, 3'b010, 32'h30, 32'h11223344, rd, er, lat, bok);
        tests_run++;
        if (rd !== 32'hA5A55500 || lat !== 1) begin
            tests_failed++;
            $display("FAIL both_high_rdata rdata=%h edges=%0d exp=%h/1", rd, lat, 32'hA5A55500);
        end
        do_access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, rd, er, lat, bok);
        tests_run++;
        if (rd !== 32'h11223344) begin
            tests_failed++;
            $display("FAIL both_high_write rdata=%h exp=%h", rd, 32'h11223344);
        end
    endtask

    task automatic test_busy_ignore;
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h30; wdata = 32'h0;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b1; wdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        tests_run++;
        if (ready !== 1'b1 || rdata !== 32'h11223344) begin
            tests_failed++;
            $display("FAIL busy_ignore_resp ready=%b rdata=%h exp 1/%h", ready, rdata, 32'h11223344);
        end
        mem_write = 1'b0;
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, rd, er, lat, bok);
        tests_run++;
        if (rd !== 32'h11223344) begin
            tests_failed++;
            $display("FAIL busy_ignore_nowrite rdata=%h exp=%h", rd, 32'h11223344);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] rp;
        logic [5:0] bp;
        rp = '0;
        bp = '0;
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h30;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            rp[k] = ready;
            bp[k] = busy;
            if (k == 4) mem_read = 1'b0;
        end
        tests_run++;
        if (rp !== 6'b010010) begin
            tests_failed++;
            $display("FAIL b2b_ready got=%b exp=%b", rp, 6'b010010);
        end
        tests_run++;
        if (bp !== 6'b011011) begin
            tests_failed++;
            $display("FAIL b2b_busy got=%b exp=%b", bp, 6'b011011);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misalign;
        logic        exp_err;
        logic [31:0] exp_word;
        logic [31:0] exp_lw;
        logic [31:0] exp_lh;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        exp_err  = 1'b1;
        exp_word = 32'h0;
        exp_lw   = 32'h0;
        exp_lh   = 32'h0;
`else
        exp_err  = 1'b0;
        exp_word = 32'hFFFFFFFF;
        exp_lw   = 32'hFFFFFFFF;
        exp_lh   = 32'hFFFFFFFF;
`endif
        do_access(1'b0, 1'b1, 3'b010, 32'h40, 32'h0, rd, er, lat, bok);
        tests_run++;
        if (er !== 1'b0) begin
            tests_failed++;
            $display("FAIL aligned_error error=%b exp=0", er);
        end
        do_access(1'b0, 1'b1, 3'b010, 32'h41, 32'hFFFFFFFF, rd, er, lat, bok);
        tests_run++;
        if (er !== exp_err || lat !== 1) begin
            tests_failed++;
            $display("FAIL misalign_sw_error error=%b edges=%0d exp=%b/1", er, lat, exp_err);
        end
        tests_run++;
        if (error !== 1'b0) begin
            tests_failed++;
            $display("FAIL error_outside_resp error=%b exp=0", error);
        end
        do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat, bok);
        tests_run++;
        if (rd !== exp_word) begin
            tests_failed++;
            $display("FAIL misalign_sw_word rdata=%h exp=%h", rd, exp_word);
        end
        do_access(1'b1, 1'b0, 3'b010, 32'h43, 32'h0, rd, er, lat, bok);
        tests_run++;
        if (rd !== exp_lw || er !== exp_err) begin
            tests_failed++;
            $display("FAIL misalign_lw rdata=%h error=%b exp=%h/%b", rd, er, exp_lw, exp_err);
        end
        do_access(1'b1, 1'b0, 3'b001, 32'h41, 32'h0, rd, er, lat, bok);
        tests_run++;
        if (rd !== exp_lh || er !== exp_err) begin
            tests_failed++;
            $display("FAIL misalign_lh rdata=%h error=%b exp=%h/%b", rd, er, exp_lh, exp_err);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_word();
        test_load_ext();
        test_store_lanes();
        test_reset_mid();
        test_both_high();
        test_busy_ignore();
        test_back_to_back();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
